// File: rtl/cbus_pkg.sv
// Shared CBUS definitions: command encoding, bus data width and the
// sequencer state encoding used by the memory master.
package cbus_pkg;

  localparam logic CBUS_CMD_WR = 1'b1;
  localparam logic CBUS_CMD_RD = 1'b0;
  localparam int   CBUS_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RDATA = 3'd2,
    ST_GAP   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/cbus_req_if.sv
// CBUS request channel: holds one outstanding request, detects the matching
// handshake and times out a request that is never answered.
module cbus_req_if
  import cbus_pkg::*;
#(
  parameter int DW          = 32,
  parameter int CBUS_AW     = 10,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               sreset,
  input  logic               issue,
  input  logic               issue_cmd,
  input  logic [CBUS_AW-1:0] issue_addr,
  input  logic [DW-1:0]      issue_wdata,
  output logic               accepted,
  output logic               rdata_valid,
  output logic               timeout,
  output logic               cbus_req,
  output logic               cbus_cmd,
  output logic [CBUS_AW-1:0] cbus_addr,
  output logic [DW-1:0]      cbus_wdata,
  input  logic               cbus_waccept,
  input  logic               cbus_rresp
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LOAD = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [TW-1:0] wait_cnt;
  logic          hs_wr;
  logic          hs_rd;

  // Handshakes of the wrong type, or with no request pending, are ignored.
  assign hs_wr    = cbus_req && (cbus_cmd == CBUS_CMD_WR) && cbus_waccept;
  assign hs_rd    = cbus_req && (cbus_cmd == CBUS_CMD_RD) && cbus_rresp;
  assign accepted = hs_wr || hs_rd;
  assign timeout  = (TIMEOUT_CYC != 0) && cbus_req && !accepted && (wait_cnt == '0);

  // Down-counter loaded on issue; terminal count on the last allowed cycle.
  always_ff @(posedge clk) begin
    if (sreset) begin
      cbus_req    <= 1'b0;
      cbus_cmd    <= 1'b0;
      cbus_addr   <= '0;
      cbus_wdata  <= '0;
      wait_cnt    <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= hs_rd;
      if (issue) begin
        cbus_req   <= 1'b1;
        cbus_cmd   <= issue_cmd;
        cbus_addr  <= issue_addr;
        cbus_wdata <= (issue_cmd == CBUS_CMD_WR) ? issue_wdata : '0;
        wait_cnt   <= TO_LOAD;
      end else if (accepted || timeout) begin
        cbus_req <= 1'b0;
      end else if (cbus_req && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbus_mem_master.sv
// CBUS block-transfer master: write-fill of an incrementing pattern and
// read-compare against the same pattern, with mismatch and timeout reporting.
//
// state | meaning
// IDLE  | wait for start, latch operation parameters
// REQ   | request outstanding on CBUS
// RDATA | read data on the bus, compare against pattern
// GAP   | one idle bus cycle, advance index or finish
// FIN   | operation complete, done pulse follows
module cbus_mem_master
  import cbus_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 10,
  parameter int CBUS_AW     = AW,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ERR_CW      = 16
) (
  input  logic                   clk,
  input  logic                   sreset,
  input  logic                   start,
  input  logic                   op,
  input  logic [AW-1:0]          base_addr,
  input  logic [AW:0]            num_words,
  input  logic [DW-1:0]          seed,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [ERR_CW-1:0]      err_cnt,
  output logic [AW-1:0]          first_err_addr,
  output logic                   first_err_valid,
  output logic                   timeout_err,
  output logic                   cbus_req,
  output logic                   cbus_cmd,
  output logic [CBUS_AW-1:0]     cbus_addr,
  output logic [DW-1:0]          cbus_wdata,
  input  logic                   cbus_waccept,
  input  logic                   cbus_rresp,
  input  logic [CBUS_DATA_W-1:0] cbus_rddata
);

  state_t                 state;
  state_t                 state_n;
  logic                   op_q;
  logic [AW:0]            num_q;
  logic [AW:0]            idx;
  logic [AW:0]            idx_inc;
  logic [AW-1:0]          cur_addr;
  logic [DW-1:0]          cur_pat;
  logic [AW-1:0]          iss_addr;
  logic [DW-1:0]          iss_pat;
  logic                   iss_cmd;
  logic                   issue;
  logic                   accepted;
  logic                   rdata_valid;
  logic                   timeout;
  logic [CBUS_DATA_W-1:0] exp_data;
  logic                   mismatch;

  assign idx_inc = idx + 1'b1;

  cbus_req_if #(
    .DW          (DW),
    .CBUS_AW     (CBUS_AW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_req_if (
    .clk          (clk),
    .sreset       (sreset),
    .issue        (issue),
    .issue_cmd    (iss_cmd),
    .issue_addr   (CBUS_AW'(iss_addr)),
    .issue_wdata  (iss_pat),
    .accepted     (accepted),
    .rdata_valid  (rdata_valid),
    .timeout      (timeout),
    .cbus_req     (cbus_req),
    .cbus_cmd     (cbus_cmd),
    .cbus_addr    (cbus_addr),
    .cbus_wdata   (cbus_wdata),
    .cbus_waccept (cbus_waccept),
    .cbus_rresp   (cbus_rresp)
  );

  always_ff @(posedge clk) begin
    if (sreset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // In IDLE the first request is built straight from the start inputs.
  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    iss_cmd  = (op_q == 1'b0) ? CBUS_CMD_WR : CBUS_CMD_RD;
    iss_addr = cur_addr + 1'b1;
    iss_pat  = cur_pat + 1'b1;
    case (state)
      ST_IDLE: begin
        iss_cmd  = (op == 1'b0) ? CBUS_CMD_WR : CBUS_CMD_RD;
        iss_addr = base_addr;
        iss_pat  = seed;
        if (start) begin
          if (num_words == '0) begin
            state_n = ST_FIN;
          end else begin
            state_n = ST_REQ;
            issue   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (timeout)
          state_n = ST_FIN;
        else if (accepted)
          state_n = (cbus_cmd == CBUS_CMD_WR) ? ST_GAP : ST_RDATA;
      end
      ST_RDATA: state_n = ST_GAP;
      ST_GAP: begin
        if ((idx_inc == num_q) || abort) begin
          state_n = ST_FIN;
        end else begin
          state_n = ST_REQ;
          issue   = 1'b1;
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    exp_data           = '0;
    exp_data[DW-1:0]   = cur_pat;
    mismatch           = (cbus_rddata != exp_data);
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      err_cnt         <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      timeout_err     <= 1'b0;
      op_q            <= 1'b0;
      num_q           <= '0;
      idx             <= '0;
      cur_addr        <= '0;
      cur_pat         <= '0;
    end else begin
      busy <= (state_n != ST_IDLE);
      done <= (state == ST_FIN);
      if (issue) begin
        cur_addr <= iss_addr;
        cur_pat  <= iss_pat;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q            <= op;
            num_q           <= num_words;
            idx             <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            timeout_err     <= 1'b0;
          end
        end
        ST_REQ: begin
          if (timeout) timeout_err <= 1'b1;
        end
        ST_RDATA: begin
          if (rdata_valid && mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!first_err_valid) begin
              first_err_addr  <= cur_addr;
              first_err_valid <= 1'b1;
            end
          end
        end
        ST_GAP:  idx <= idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_mem_master.sv
// Directed bench for cbus_mem_master: behavioural CBUS slave with adjustable
// stall and a scoreboard of expected bus transactions.
module tb_cbus_mem_master;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          sreset, start, op, abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic [DW-1:0] seed;
  logic          busy, done, first_err_valid, timeout_err;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic          cbus_req, cbus_cmd, cbus_waccept, cbus_rresp;
  logic [AW-1:0] cbus_addr;
  logic [DW-1:0] cbus_wdata;
  logic [31:0]   cbus_rddata = 32'h0;

  logic waccept_m = 1'b0, rresp_m = 1'b0, spur_wacc = 1'b0, spur_rresp = 1'b0;
  assign cbus_waccept = waccept_m | spur_wacc;
  assign cbus_rresp   = rresp_m | spur_rresp;

  typedef struct packed {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xact_t;

  xact_t         sb[$];
  xact_t         sb_e;
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_addr;
  logic          req_prev = 1'b0;
  int            delay = 1, seen = 0, req_hi = 0, n_hs = 0, n_req_rise = 0;
  int            first_hs = -1, last_hs = 0, cyc = 0, n_done = 0;
  int            n_assert = 0, n_fail = 0;
  int            h0, d0, r0;

  cbus_mem_master #(
    .DW(DW), .AW(AW), .CBUS_AW(AW), .TIMEOUT_CYC(1024), .ERR_CW(16)
  ) dut (
    .clk(clk), .sreset(sreset), .start(start), .op(op), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .abort(abort), .busy(busy), .done(done),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .first_err_valid(first_err_valid), .timeout_err(timeout_err),
    .cbus_req(cbus_req), .cbus_cmd(cbus_cmd), .cbus_addr(cbus_addr),
    .cbus_wdata(cbus_wdata), .cbus_waccept(cbus_waccept),
    .cbus_rresp(cbus_rresp), .cbus_rddata(cbus_rddata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: responds on the (delay+1)-th request cycle; pulses cover one edge.
  always @(negedge clk) begin
    if (rresp_m) begin
      rresp_m     = 1'b0;
      cbus_rddata = mem[rd_addr];
    end
    waccept_m = 1'b0;
    if (cbus_req === 1'b1 && req_prev !== 1'b1) n_req_rise++;
    req_prev = cbus_req;
    if (cbus_req === 1'b1) begin
      seen++;
      req_hi++;
      if (seen > delay) begin
        n_hs++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          sb_e = sb.pop_front();
          check("xact_cmd", cbus_cmd, sb_e.cmd);
          check("xact_addr", cbus_addr, sb_e.addr);
          check("xact_wdata", cbus_wdata, sb_e.data);
        end
        if (cbus_cmd) begin
          waccept_m          = 1'b1;
          mem[cbus_addr]     = 32'(cbus_wdata);
        end else begin
          rresp_m = 1'b1;
          rd_addr = cbus_addr;
        end
      end
    end else begin
      seen = 0;
    end
  end

  task automatic push_range(input logic o, input int b, input int n, input int s);
    xact_t x;
    for (int i = 0; i < n; i++) begin
      x.cmd  = (o == 1'b0);
      x.addr = AW'(b + i);
      x.data = o ? '0 : DW'(s + i);
      sb.push_back(x);
    end
  endtask

  task automatic start_op(input logic o, input int b, input int n, input int s);
    @(negedge clk);
    op        = o;
    base_addr = AW'(b);
    num_words = (AW+1)'(n);
    seed      = DW'(s);
    start     = 1'b1;
    first_hs  = -1;
    req_hi    = 0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    sreset = 1'b1; start = 1'b0; op = 1'b0; abort = 1'b0;
    base_addr = '0; num_words = '0; seed = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", cbus_req, 0);
    check("rst_cmd", cbus_cmd, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_first_err_valid", first_err_valid, 0);
    check("rst_addr", cbus_addr, 0);
    check("rst_wdata", cbus_wdata, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_err_addr", first_err_addr, 0);
    sreset = 1'b0;

    // write-fill across the address wrap
    delay = 1; h0 = n_hs; d0 = n_done;
    push_range(1'b0, 'h3F0, 32, 'hA5);
    start_op(1'b0, 'h3F0, 32, 'hA5);
    wait_done("wf_done", 200);
    check("wf_timeout_err", timeout_err, 0);
    check("wf_busy_at_done", busy, 0);
    repeat (2) @(negedge clk);
    check("wf_count", n_hs - h0, 32);
    check("wf_sb_empty", sb.size(), 0);
    check("wf_throughput", last_hs - first_hs, 3 * 31);
    check("wf_done_pulses", n_done - d0, 1);

    // clean read-compare
    h0 = n_hs; d0 = n_done;
    push_range(1'b1, 'h3F0, 32, 'hA5);
    start_op(1'b1, 'h3F0, 32, 'hA5);
    wait_done("rc_done", 250);
    check("rc_err_cnt", err_cnt, 0);
    check("rc_first_err_valid", first_err_valid, 0);
    repeat (2) @(negedge clk);
    check("rc_count", n_hs - h0, 32);
    check("rc_throughput", last_hs - first_hs, 4 * 31);
    check("rc_done_pulses", n_done - d0, 1);

    // corrupted read-compare: data error on 0x005, out-of-width bit on 0x007
    mem[5] = mem[5] ^ 32'h1;
    mem[7] = mem[7] | 32'h8000_0000;
    push_range(1'b1, 'h3F0, 32, 'hA5);
    start_op(1'b1, 'h3F0, 32, 'hA5);
    wait_done("rx_done", 250);
    check("rx_err_cnt", err_cnt, 2);
    check("rx_first_err_addr", first_err_addr, 'h005);
    check("rx_first_err_valid", first_err_valid, 1);

    // 500-cycle stall with a wrong-type response mid-request
    delay = 500; h0 = n_hs;
    push_range(1'b0, 'h200, 2, 'h1234);
    start_op(1'b0, 'h200, 2, 'h1234);
    repeat (20) @(negedge clk);
    spur_rresp = 1'b1;
    @(negedge clk);
    spur_rresp = 1'b0;
    wait_done("st500_done", 3000);
    check("st500_timeout_err", timeout_err, 0);
    check("st500_count", n_hs - h0, 2);
    check("st500_sb_empty", sb.size(), 0);

    // longest stall that still completes
    delay = 1023; h0 = n_hs;
    push_range(1'b0, 'h210, 1, 'h99);
    start_op(1'b0, 'h210, 1, 'h99);
    wait_done("st1023_done", 2000);
    check("st1023_timeout_err", timeout_err, 0);
    check("st1023_req_cycles", req_hi, 1024);
    check("st1023_count", n_hs - h0, 1);

    // stall past the limit
    delay = 1024; h0 = n_hs;
    start_op(1'b0, 'h220, 2, 'h11);
    wait_done("to_done", 2000);
    check("to_timeout_err", timeout_err, 1);
    check("to_req_dropped", cbus_req, 0);
    check("to_req_cycles", req_hi, 1024);
    check("to_count", n_hs - h0, 0);
    check("to_sb_empty", sb.size(), 0);

    // abort during the third request
    delay = 1; h0 = n_hs; r0 = n_req_rise;
    push_range(1'b0, 'h080, 3, 'h7);
    start_op(1'b0, 'h080, 10, 'h7);
    for (int k = 0; k < 100 && (n_req_rise - r0) < 3; k++) @(negedge clk);
    abort = 1'b1;
    wait_done("ab_done", 100);
    abort = 1'b0;
    check("ab_timeout_cleared", timeout_err, 0);
    repeat (2) @(negedge clk);
    check("ab_count", n_hs - h0, 3);
    check("ab_sb_empty", sb.size(), 0);

    // zero-length transfer
    r0 = n_req_rise; d0 = n_done;
    @(negedge clk);
    op = 1'b0; num_words = '0; base_addr = 'h123; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zl_busy", busy, 1);
    check("zl_done_early", done, 0);
    @(negedge clk);
    check("zl_done", done, 1);
    repeat (2) @(negedge clk);
    check("zl_no_req", n_req_rise - r0, 0);
    check("zl_done_pulses", n_done - d0, 1);

    // synchronous reset while a request is outstanding
    delay = 5; h0 = n_hs; d0 = n_done;
    start_op(1'b0, 'h300, 4, 'h1);
    check("sr_req_up", cbus_req, 1);
    sreset = 1'b1;
    @(negedge clk);
    check("sr_req_dropped", cbus_req, 0);
    check("sr_busy", busy, 0);
    sreset = 1'b0;
    repeat (10) @(negedge clk);
    check("sr_no_done", n_done - d0, 0);
    check("sr_no_xact", n_hs - h0, 0);

    // start while busy is ignored
    delay = 1; h0 = n_hs; d0 = n_done;
    push_range(1'b0, 'h040, 4, 'h55);
    start_op(1'b0, 'h040, 4, 'h55);
    repeat (2) @(negedge clk);
    op = 1'b1; base_addr = 'h100; num_words = 7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sb_busy_held", busy, 1);
    check("sb_cmd_held", cbus_cmd, 1);
    wait_done("swb_done", 100);
    repeat (2) @(negedge clk);
    check("swb_count", n_hs - h0, 4);
    check("swb_sb_empty", sb.size(), 0);
    check("swb_done_pulses", n_done - d0, 1);

    // spurious handshakes while idle
    d0 = n_done;
    spur_rresp = 1'b1; spur_wacc = 1'b1;
    @(negedge clk);
    spur_rresp = 1'b0; spur_wacc = 1'b0;
    repeat (3) @(negedge clk);
    check("sp_busy", busy, 0);
    check("sp_req", cbus_req, 0);
    check("sp_err_cnt", err_cnt, 0);
    check("sp_addr_held", cbus_addr, 'h043);
    check("sp_no_done", n_done - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
